irq_arbiter: RTL and testbench
==============================

IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameters: none; request width fixed at 8, index width fixed at 3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  raw level request lines; bit 7 highest priority, bit 0 lowest.
REQ-005 out_ready  input  1  downstream accepts the presented index when high with out_valid.
REQ-006 mask  input  8  per-bit eligibility mask, 1 = blocked; present only when IRQ_MASK_EN is defined.
REQ-007 out_idx  output  3  binary index of the granted request, registered.
REQ-008 out_valid  output  1  out_idx holds a granted request, registered.
REQ-009 pending  output  8  captured-but-unserviced requests, registered.
REQ-010 overrun  output  1  one-cycle pulse: new edge hit an already-pending bit.

Function
REQ-011 Block SHALL register req into req_q each cycle; new = req & ~req_q (rising-edge detect per bit).
REQ-012 pending SHALL update as pending_next = (pending & ~clr) | new, where clr is the one-hot of out_idx when out_valid & out_ready, else 0.
REQ-013 Same-bit simultaneous clr and new SHALL leave the bit set (new edge re-arms; no overrun).
REQ-014 overrun SHALL be 1 in the cycle after new[i] & pending[i] & ~clr[i] for any i; the duplicate is coalesced, not counted.
REQ-015 eligible SHALL be pending (without macro) or pending & ~mask (with macro).
REQ-016 Selection SHALL be the highest-numbered set bit of eligible; codes 3'b000..3'b111 equal bit number.
REQ-017 FSM SHALL have two states: IDLE (out_valid=0) and GRANT (out_valid=1).
REQ-018 IDLE -> GRANT when eligible != 0; out_idx loads the selected index on the same edge.
REQ-019 GRANT: out_idx SHALL remain stable until out_valid & out_ready; changes to pending, req or mask SHALL NOT alter it.
REQ-020 GRANT -> IDLE on out_valid & out_ready; pending[out_idx] cleared on that edge.
REQ-021 GRANT with out_ready=0 SHALL hold indefinitely; pending may continue to accumulate.
REQ-022 Latency: req rising sampled at edge k -> pending bit set after k -> out_valid=1 after edge k+1.
REQ-023 Throughput: at most one grant per two cycles (one IDLE bubble after every handshake).
REQ-024 out_idx in IDLE SHALL hold its last value (don't-care to consumers, but deterministic).

Reset
REQ-025 On rst=1 at a clock edge: req_q, pending, out_idx, out_valid, overrun SHALL all be 0; FSM = IDLE.
REQ-026 Reset mid-GRANT SHALL drop the grant with no handshake; the request is lost.
REQ-027 A req bit held high through reset release SHALL register as a new edge on the first cycle after release (req_q resets to 0).

Configuration
REQ-028 Macro IRQ_MASK_EN: defined -> mask port exists and gates eligibility per REQ-015; masked bits still capture and pend.
REQ-029 IRQ_MASK_EN undefined -> no mask port; all pending bits eligible.
REQ-030 With IRQ_MASK_EN, unmasking a pending bit SHALL make it eligible on the next IDLE evaluation; masking in GRANT does not withdraw the grant.

Verification
REQ-031 Reset, then req=8'h01 held, out_ready=1 -> pending=8'h01 after 1 edge, out_valid=1/out_idx=0 after 2, pending=8'h00 after handshake, no re-grant while req held.
REQ-032 req rises 8'h00->8'h94 in one cycle, out_ready=1 -> grants in order idx 7, 4, 2, each separated by one IDLE cycle; pending ends 8'h00.
REQ-033 Grant idx 3 with out_ready=0 for 10 cycles while req bit 6 pulses -> out_idx stays 3 throughout, pending=8'h48; after ready, next grant idx 6.
REQ-034 Bit 5 pending, pulse req[5] again before service -> overrun=1 for exactly one cycle, pending[5] stays 1, single grant idx 5.
REQ-035 rst asserted during GRANT idx 2 -> next cycle out_valid=0, pending=8'h00, overrun=0; req[2] still high -> regranted idx 2 two cycles after release.
REQ-036 IRQ_MASK_EN defined, mask=8'h80, req=8'h81 rising -> grant idx 0 only, pending=8'h80 retained; clear mask -> grant idx 7.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter: 8-line edge-captured interrupt arbiter with a valid/ready grant port.
//
// Rising edges on req are captured into pending. Whenever the arbiter is idle and any
// pending bit is eligible, it grants the highest-numbered one and holds that index on
// out_idx until the consumer accepts it (out_valid & out_ready). Each handshake clears
// the granted pending bit and is followed by one idle cycle before the next grant.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst        - synchronous active-high reset
//   req[7:0]   - level request lines, bit 7 highest priority
//   out_ready  - consumer accepts out_idx when high together with out_valid
//   mask[7:0]  - 1 = bit not eligible for grant (only with IRQ_MASK_EN defined)
//   out_idx    - registered index of the current/last grant
//   out_valid  - registered, out_idx holds a live grant
//   pending    - registered captured-but-unserviced requests
//   overrun    - registered one-cycle pulse: a new edge hit an already-pending bit
//
// Build option: define IRQ_MASK_EN to add the mask port. Masked bits still capture and
// pend; they are only withheld from selection.

module irq_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       out_ready,
`ifdef IRQ_MASK_EN
  input  logic [7:0] mask,
`endif
  output logic [2:0] out_idx,
  output logic       out_valid,
  output logic [7:0] pending,
  output logic       overrun
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [7:0] req_q;
  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic [2:0] out_idx_q;
  logic       out_valid_q;
  logic       overrun_q;

  logic [7:0] new_edge;
  logic [7:0] clr;
  logic [7:0] eligible;
  logic [2:0] sel_idx;
  logic       handshake;

  always_comb begin
    new_edge  = req & ~req_q;
    handshake = (state_q == StGrant) && out_ready;
    clr       = handshake ? (8'b1 << out_idx_q) : 8'b0;
    // A new edge on the bit being cleared re-arms it.
    pending_d = (pending_q & ~clr) | new_edge;
`ifdef IRQ_MASK_EN
    eligible  = pending_q & ~mask;
`else
    eligible  = pending_q;
`endif
  end

  // Highest-numbered eligible bit wins: later iterations override earlier ones.
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) begin
        sel_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_q       <= 8'h00;
      pending_q   <= 8'h00;
      out_idx_q   <= 3'd0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      req_q     <= req;
      pending_q <= pending_d;
      overrun_q <= |(new_edge & pending_q & ~clr);
      unique case (state_q)
        StIdle: begin
          if (|eligible) begin
            state_q     <= StGrant;
            out_valid_q <= 1'b1;
            out_idx_q   <= sel_idx;
          end
        end
        StGrant: begin
          // out_idx is frozen here; only the handshake releases the grant.
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter. Expected grant indices are queued when the
// stimulus is applied and compared on each observed handshake; state outputs are
// checked directly at fixed points in each scenario.

module tb_irq_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       out_ready;
  logic [7:0] mask;
  logic [2:0] out_idx;
  logic       out_valid;
  logic [7:0] pending;
  logic       overrun;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned exp_q[$];

  irq_arbiter u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
`ifdef IRQ_MASK_EN
    .mask      (mask),
`endif
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .pending   (pending),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are stable and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted grant must match the next queued index.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check_eq("sb_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check_eq("sb_grant_idx", out_idx, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout 1 expected 0");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req       = 8'h00;
    out_ready = 1'b0;
    mask      = 8'h00;
    step();
    step();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_pending", pending, 8'h00);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_idx", out_idx, 0);
    rst = 1'b0;

    // Single held request: capture, grant, clear, no re-grant while held.
    exp_q.push_back(0);
    req       = 8'h01;
    out_ready = 1'b1;
    step();
    check_eq("t31_pend1", pending, 8'h01);
    check_eq("t31_valid0", out_valid, 0);
    step();
    check_eq("t31_valid1", out_valid, 1);
    check_eq("t31_idx", out_idx, 0);
    step();
    check_eq("t31_pend_clr", pending, 8'h00);
    check_eq("t31_idle", out_valid, 0);
    repeat (3) step();
    check_eq("t31_no_regrant", out_valid, 0);
    req = 8'h00;
    step();

    // Three simultaneous edges granted by priority with an idle bubble between.
    exp_q.push_back(7);
    exp_q.push_back(4);
    exp_q.push_back(2);
    req = 8'h94;
    step();
    check_eq("t32_pend", pending, 8'h94);
    step();
    check_eq("t32_g7", out_idx, 7);
    step();
    check_eq("t32_bubble1", out_valid, 0);
    check_eq("t32_pend14", pending, 8'h14);
    step();
    check_eq("t32_g4", out_idx, 4);
    check_eq("t32_v4", out_valid, 1);
    step();
    check_eq("t32_bubble2", out_valid, 0);
    step();
    check_eq("t32_g2", out_idx, 2);
    step();
    check_eq("t32_pend_end", pending, 8'h00);
    check_eq("t32_idle", out_valid, 0);
    req = 8'h00;
    step();

    // Stalled grant stays frozen while a higher request arrives.
    exp_q.push_back(3);
    exp_q.push_back(6);
    out_ready = 1'b0;
    req       = 8'h08;
    step();
    req = 8'h00;
    step();
    check_eq("t33_valid", out_valid, 1);
    req = 8'h40;
    for (int i = 0; i < 10; i++) begin
      step();
      req = 8'h00;
      check_eq("t33_hold_idx", out_idx, 3);
      check_eq("t33_hold_valid", out_valid, 1);
    end
    check_eq("t33_pend", pending, 8'h48);
    out_ready = 1'b1;
    step();
    check_eq("t33_pend40", pending, 8'h40);
    check_eq("t33_bubble", out_valid, 0);
    step();
    check_eq("t33_g6", out_idx, 6);
    step();
    check_eq("t33_pend_end", pending, 8'h00);

    // Duplicate edge on a pending bit: one overrun pulse, one grant.
    exp_q.push_back(5);
    out_ready = 1'b0;
    req       = 8'h20;
    step();
    check_eq("t34_ovr_first", overrun, 0);
    req = 8'h00;
    step();
    req = 8'h20;
    step();
    check_eq("t34_ovr", overrun, 1);
    check_eq("t34_pend", pending, 8'h20);
    req = 8'h00;
    step();
    check_eq("t34_ovr_pulse", overrun, 0);
    check_eq("t34_idx", out_idx, 5);
    out_ready = 1'b1;
    step();
    check_eq("t34_pend_clr", pending, 8'h00);
    step();
    check_eq("t34_single", out_valid, 0);

    // Reset in the middle of a grant; held request re-captured after release.
    exp_q.push_back(2);
    out_ready = 1'b0;
    req       = 8'h04;
    step();
    step();
    check_eq("t35_grant", out_valid, 1);
    check_eq("t35_idx", out_idx, 2);
    rst = 1'b1;
    step();
    check_eq("t35_rst_valid", out_valid, 0);
    check_eq("t35_rst_pend", pending, 8'h00);
    check_eq("t35_rst_ovr", overrun, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("t35_recapture", pending, 8'h04);
    check_eq("t35_valid0", out_valid, 0);
    step();
    check_eq("t35_regrant", out_valid, 1);
    check_eq("t35_reidx", out_idx, 2);
    step();
    check_eq("t35_pend_end", pending, 8'h00);
    req = 8'h00;
    step();

`ifdef IRQ_MASK_EN
    // Masked bit pends but waits until unmasked.
    exp_q.push_back(0);
    exp_q.push_back(7);
    mask = 8'h80;
    req  = 8'h81;
    step();
    check_eq("tm_pend", pending, 8'h81);
    step();
    check_eq("tm_g0", out_idx, 0);
    step();
    check_eq("tm_pend80", pending, 8'h80);
    step();
    check_eq("tm_blocked", out_valid, 0);
    mask = 8'h00;
    step();
    check_eq("tm_g7_valid", out_valid, 1);
    check_eq("tm_g7", out_idx, 7);
    step();
    check_eq("tm_pend_end", pending, 8'h00);
    req = 8'h00;
    step();
`endif

    step();
    check_eq("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
